// File: rtl/dot_matrix_capture.sv
// dot_matrix_capture
// Watches the row-select / column bus of the 8x8 dot-matrix row-scan driver
// and rebuilds the 64-bit frame being shown. Row k's column byte lands in
// o_Frame[8k+7:8k], which is the same layout as the driver's frame input.
//
// The monitor checks every scan step. Rows must be one-hot. They must ascend
// with a 7->0 wrap. Each row must be held for between MIN_DWELL and MAX_DWELL
// cycles. Any violation pulses o_fErr and drops back to SYNC, which then waits
// for the next change to row 8'h01 before it locks again.
//
// Handshake: there is no back-pressure. o_fValid and o_fErr are single-cycle
// strobes. o_Frame and o_FrameCnt are only meaningful while o_fValid is high,
// and they hold their values between strobes.
//
// All outputs are registered. No input reaches an output combinationally.

module dot_matrix_capture #(
  parameter int SETTLE    = 1,       // cycles after a row change before sampling columns (< MIN_DWELL)
  parameter int MIN_DWELL = 100000,  // minimum legal row dwell in cycles
  parameter int MAX_DWELL = 100000,  // maximum legal row dwell in cycles (>= MIN_DWELL)
  parameter int CNT_W     = 18       // dwell counter width, must hold MAX_DWELL
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [7:0]  i_DM_Row,
  input  logic [7:0]  i_DM_Col,
  output logic [63:0] o_Frame,
  output logic        o_fValid,
  output logic        o_fErr,
  output logic        o_Sync,
  output logic [7:0]  o_FrameCnt
);

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] TOUT_C   = CNT_W'(MAX_DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   MIN_C    = (CNT_W + 1)'(MIN_DWELL);
  localparam logic [CNT_W:0]   DWELL_1  = (CNT_W + 1)'(1);

  state_t           state_q;
  logic [7:0]       prev_row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0][7:0]  shadow_q;

  logic             row_change;
  logic             row_onehot;
  logic [CNT_W:0]   dwell_n;
  logic [2:0]       idx_inc;
  logic [7:0]       exp_row;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx_nxt;
  logic             acquire;
  logic             scan_err;
  logic             advance;
  logic             wrap;
  logic             cap_en;
  state_t           state_nxt;

  // Scan decode: change detect, dwell of the outgoing row, legality checks
  // and the next-state / capture decisions.
  always_comb begin
    row_change = (i_DM_Row != prev_row_q);
    row_onehot = (i_DM_Row != 8'h00) && ((i_DM_Row & (i_DM_Row - 8'd1)) == 8'h00);
    // The counter reads 0 on the first non-change cycle, so the dwell is count+1.
    dwell_n    = {1'b0, cnt_q} + DWELL_1;
    idx_inc    = idx_q + 3'd1;
    exp_row    = 8'd1 << idx_inc;

    if (row_change) begin
      cnt_nxt = '0;
    end else if (cnt_q == MAX_C) begin
      cnt_nxt = MAX_C;
    end else begin
      cnt_nxt = cnt_q + CNT_ONE;
    end

    acquire  = 1'b0;
    scan_err = 1'b0;
    advance  = 1'b0;
    if (state_q == ST_SYNC) begin
      acquire = row_change && (i_DM_Row == 8'h01);
    end else if (row_change) begin
      // A change always wins over a timeout in the same cycle.
      if (!row_onehot || (dwell_n < MIN_C) || (i_DM_Row != exp_row)) begin
        scan_err = 1'b1;
      end else begin
        advance = 1'b1;
      end
    end else if (cnt_q == TOUT_C) begin
      scan_err = 1'b1;
    end

    wrap = advance && (idx_q == 3'd7);

    if (acquire) begin
      idx_nxt = 3'd0;
    end else if (advance) begin
      idx_nxt = idx_inc;
    end else begin
      idx_nxt = idx_q;
    end

    // Sample the column byte once per row, SETTLE cycles into the row.
    // Using the next index keeps SETTLE=0 correct on the change edge itself.
    cap_en = (acquire || ((state_q == ST_CAPTURE) && !scan_err)) && (cnt_nxt == SETTLE_C);

    if (acquire) begin
      state_nxt = ST_CAPTURE;
    end else if (scan_err) begin
      state_nxt = ST_SYNC;
    end else begin
      state_nxt = state_q;
    end
  end

  // State, dwell tracking, shadow capture and the registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_SYNC;
      prev_row_q <= 8'h00;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shadow_q   <= '0;
      o_Frame    <= 64'h0;
      o_fValid   <= 1'b0;
      o_fErr     <= 1'b0;
      o_Sync     <= 1'b0;
      o_FrameCnt <= 8'h00;
    end else begin
      state_q    <= state_nxt;
      prev_row_q <= i_DM_Row;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      o_Sync     <= (state_nxt == ST_CAPTURE);
      o_fValid   <= wrap;
      o_fErr     <= scan_err;

      // A partial frame is thrown away on error or when locking again.
      if (scan_err || acquire) begin
        shadow_q <= '0;
      end
      if (cap_en) begin
        shadow_q[idx_nxt] <= i_DM_Col;
      end

      // The old shadow (all 8 bytes) is published while row 0 of the next
      // frame starts capturing.
      if (wrap) begin
        o_Frame    <= shadow_q;
        o_FrameCnt <= o_FrameCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_capture.sv
// Bench for dot_matrix_capture with SETTLE=1, MIN_DWELL=MAX_DWELL=4.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled at
// that same point, after the edge has updated them.

module tb_dot_matrix_capture;

  localparam int SETTLE    = 1;
  localparam int MIN_DWELL = 4;
  localparam int MAX_DWELL = 4;
  localparam int CNT_W     = 18;

  localparam logic [63:0] FRM_F = 64'h0123456789ABCDEF;
  localparam logic [63:0] FRM_G = 64'hA5C30F967E18DB24;
  localparam logic [63:0] FRM_H = 64'h1122334455667788;
  localparam logic [63:0] FRM_J = 64'hFEDCBA9876543210;

  logic        i_Clk;
  logic        i_Rst;
  logic [7:0]  i_DM_Row;
  logic [7:0]  i_DM_Col;
  logic [63:0] o_Frame;
  logic        o_fValid;
  logic        o_fErr;
  logic        o_Sync;
  logic [7:0]  o_FrameCnt;

  int          total;
  int          bad;
  int          err_seen;
  logic [71:0] exp_q[$];
  logic [7:0]  exp_cnt;
  logic        pending;
  logic [63:0] pending_frame;

  dot_matrix_capture #(
    .SETTLE    (SETTLE),
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL),
    .CNT_W     (CNT_W)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_DM_Row   (i_DM_Row),
    .i_DM_Col   (i_DM_Col),
    .o_Frame    (o_Frame),
    .o_fValid   (o_fValid),
    .o_fErr     (o_fErr),
    .o_Sync     (o_Sync),
    .o_FrameCnt (o_FrameCnt)
  );

  // Clock and reset.
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers.
  task automatic cyc(input logic [7:0] row, input logic [7:0] col);
    i_DM_Row = row;
    i_DM_Col = col;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] row, input int n);
    for (int i = 0; i < n; i++) cyc(row, 8'h00);
  endtask

  // A completed frame is published when the next row 01 edge arrives.
  task automatic wrap_push();
    if (pending) begin
      exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back({exp_cnt, pending_frame});
      pending = 1'b0;
    end
  endtask

  task automatic scan_frame(input logic [63:0] frame, input bit garbage, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      logic [7:0] b;
      b = frame[8*r +: 8];
      if (r == 0) wrap_push();
      for (int c = 0; c < MIN_DWELL; c++) begin
        cyc(8'd1 << r, (garbage && c == 0) ? 8'hFF : b);
        if (r == 0 && c == 0) check("sync_lock", {71'd0, o_Sync}, 72'd1);
      end
    end
    if (nrows == 8) begin
      pending       = 1'b1;
      pending_frame = frame;
    end
  endtask

  // Scoreboard monitor: count error strobes and pop expected frames on o_fValid.
  initial begin
    logic [71:0] e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (o_fErr) err_seen++;
      if (o_fValid) begin
        if (exp_q.size() == 0) begin
          check("valid_unexpected", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame", {8'd0, o_Frame}, {8'd0, e[63:0]});
          check("frame_cnt", {64'd0, o_FrameCnt}, {64'd0, e[71:64]});
        end
      end
    end
  end

  // Main sequence.
  initial begin
    total = 0; bad = 0; err_seen = 0;
    exp_cnt = 8'd0; pending = 1'b0; pending_frame = 64'h0;
    i_Rst = 1'b0; i_DM_Row = 8'h00; i_DM_Col = 8'h00;

    // Reset state.
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #1;
    check("rst_frame", {8'd0, o_Frame}, 72'd0);
    check("rst_valid", {71'd0, o_fValid}, 72'd0);
    check("rst_err",   {71'd0, o_fErr}, 72'd0);
    check("rst_sync",  {71'd0, o_Sync}, 72'd0);
    check("rst_cnt",   {64'd0, o_FrameCnt}, 72'd0);
    i_Rst = 1'b1;
    hold(8'h00, 2);
    check("idle_sync", {71'd0, o_Sync}, 72'd0);

    // Legal frames, then a frame with a garbage first column cycle per row.
    scan_frame(FRM_F, 1'b0, 8);
    scan_frame(FRM_F, 1'b0, 8);
    scan_frame(FRM_G, 1'b1, 8);
    scan_frame(FRM_H, 1'b0, 8);

    // Short dwell on row 04.
    wrap_push();
    hold(8'h01, 4);
    hold(8'h02, 4);
    hold(8'h04, 3);
    cyc(8'h08, 8'h00);
    check("short_err",   {71'd0, o_fErr}, 72'd1);
    check("short_sync",  {71'd0, o_Sync}, 72'd0);
    check("short_frame", {8'd0, o_Frame}, {8'd0, FRM_H});
    hold(8'h08, 3);
    hold(8'h10, 4);
    hold(8'h00, 2);

    // Order violation 02 -> 08.
    hold(8'h01, 4);
    hold(8'h02, 4);
    cyc(8'h08, 8'h00);
    check("order_err",   {71'd0, o_fErr}, 72'd1);
    check("order_sync",  {71'd0, o_Sync}, 72'd0);
    check("order_frame", {8'd0, o_Frame}, {8'd0, FRM_H});
    hold(8'h08, 3);
    hold(8'h00, 2);

    // Non one-hot row 03.
    hold(8'h01, 4);
    hold(8'h02, 4);
    cyc(8'h03, 8'h00);
    check("onehot_err",   {71'd0, o_fErr}, 72'd1);
    check("onehot_sync",  {71'd0, o_Sync}, 72'd0);
    check("onehot_frame", {8'd0, o_Frame}, {8'd0, FRM_H});
    hold(8'h03, 3);
    hold(8'h00, 2);

    // Timeout: row 10 held five cycles.
    hold(8'h01, 4);
    hold(8'h02, 4);
    hold(8'h04, 4);
    hold(8'h08, 4);
    hold(8'h10, 4);
    check("tout_quiet", {71'd0, o_fErr}, 72'd0);
    check("tout_held",  {71'd0, o_Sync}, 72'd1);
    cyc(8'h10, 8'h00);
    check("tout_err",   {71'd0, o_fErr}, 72'd1);
    check("tout_sync",  {71'd0, o_Sync}, 72'd0);
    hold(8'h00, 2);
    check("err_count", {40'd0, 32'(err_seen)}, 72'd4);

    // Reset mid-frame during row 20 of the second frame.
    scan_frame(FRM_F, 1'b0, 8);
    scan_frame(FRM_J, 1'b0, 5);
    cyc(8'h20, FRM_J[47:40]);
    cyc(8'h20, FRM_J[47:40]);
    #3;
    i_Rst = 1'b0;
    i_DM_Row = 8'h00;
    #1;
    check("mid_rst_frame", {8'd0, o_Frame}, 72'd0);
    check("mid_rst_valid", {71'd0, o_fValid}, 72'd0);
    check("mid_rst_err",   {71'd0, o_fErr}, 72'd0);
    check("mid_rst_sync",  {71'd0, o_Sync}, 72'd0);
    check("mid_rst_cnt",   {64'd0, o_FrameCnt}, 72'd0);
    check("mid_rst_q",     {40'd0, 32'(exp_q.size())}, 72'd0);
    exp_q.delete();
    pending = 1'b0;
    exp_cnt = 8'd0;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #1;
    i_Rst = 1'b1;
    hold(8'h00, 2);
    scan_frame(FRM_J, 1'b0, 8);
    scan_frame(FRM_F, 1'b0, 1);
    cyc(8'h02, FRM_F[15:8]);
    check("drain_q",   {40'd0, 32'(exp_q.size())}, 72'd0);
    check("err_final", {40'd0, 32'(err_seen)}, 72'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
